// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card lookup, PIN check with lockout, and transaction dispatch
// against an external account store over a req/ack handshake.
module atm_session_ctrl #(
    parameter int MAX_PIN_TRIES  = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int AMT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      cardnumber,
    input  logic             card_valid,
    input  logic [19:0]      pin,
    input  logic             pin_valid,
    input  logic [2:0]       transaction,
    input  logic [AMT_W-1:0] amount,
    input  logic             txn_valid,
    output logic             acc_req,
    output logic [1:0]       acc_op,
    output logic [31:0]      acc_card,
    output logic [AMT_W-1:0] acc_wdata,
    input  logic             acc_ack,
    input  logic             acc_found,
    input  logic             acc_locked,
    input  logic [19:0]      acc_pin,
    input  logic [AMT_W-1:0] acc_balance,
    output logic [AMT_W-1:0] balance_out,
    output logic [2:0]       status,
    output logic             status_valid,
    output logic             busy,
    output logic [2:0]       dbg_state
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_CARD = 3'd1;
    localparam logic [2:0] S_LOOKUP    = 3'd2;
    localparam logic [2:0] S_WAIT_PIN  = 3'd3;
    localparam logic [2:0] S_WAIT_TXN  = 3'd4;
    localparam logic [2:0] S_EXEC      = 3'd5;
    localparam logic [2:0] S_WRITE     = 3'd6;
    localparam logic [2:0] S_LOCKING   = 3'd7;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_NO_CARD  = 3'd1;
    localparam logic [2:0] ST_BAD_PIN  = 3'd2;
    localparam logic [2:0] ST_LOCKED   = 3'd3;
    localparam logic [2:0] ST_INSUFF   = 3'd4;
    localparam logic [2:0] ST_OVERFLOW = 3'd5;
    localparam logic [2:0] ST_BAD_TXN  = 3'd6;
    localparam logic [2:0] ST_TIMEOUT  = 3'd7;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_LOCK   = 2'd2;

    logic [2:0]       state_q, state_d;
    logic [2:0]       tries_q, tries_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [31:0]      card_q, card_d;
    logic [19:0]      pin_q, pin_d;
    logic [AMT_W-1:0] bal_q, bal_d;
    logic [AMT_W-1:0] new_q, new_d;
    logic [2:0]       txn_q, txn_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             req_q, req_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       status_q, status_d;
    logic             sv_q, sv_d;

    logic [AMT_W:0]   sum;
    logic             wait_st, strobe_taken, ack;

    // acc_ack only counts while a request is outstanding.
    assign ack          = acc_ack && req_q;
    assign sum          = {1'b0, bal_q} + {1'b0, amt_q};
    assign wait_st      = (state_q == S_WAIT_CARD) || (state_q == S_WAIT_PIN) || (state_q == S_WAIT_TXN);
    assign strobe_taken = ((state_q == S_WAIT_CARD) && card_valid) ||
                          ((state_q == S_WAIT_PIN)  && pin_valid)  ||
                          ((state_q == S_WAIT_TXN)  && txn_valid);

    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        card_d   = card_q;
        pin_d    = pin_q;
        bal_d    = bal_q;
        new_d    = new_q;
        txn_d    = txn_q;
        amt_d    = amt_q;
        req_d    = req_q;
        op_d     = op_q;
        status_d = status_q;
        sv_d     = 1'b0;
        tmo_d    = (wait_st && !strobe_taken) ? tmo_q + 1'b1 : '0;

        case (state_q)
            S_IDLE: if (start) state_d = S_WAIT_CARD;
            S_WAIT_CARD: if (card_valid) begin
                card_d  = cardnumber;
                req_d   = 1'b1;
                op_d    = OP_LOOKUP;
                state_d = S_LOOKUP;
            end
            S_LOOKUP: if (ack) begin
                req_d = 1'b0;
                if (!acc_found) begin
                    status_d = ST_NO_CARD; sv_d = 1'b1; state_d = S_IDLE;
                end else if (acc_locked) begin
                    status_d = ST_LOCKED; sv_d = 1'b1; state_d = S_IDLE;
                end else begin
                    pin_d   = acc_pin;
                    bal_d   = acc_balance;
                    tries_d = 3'd0;
                    state_d = S_WAIT_PIN;
                end
            end
            S_WAIT_PIN: if (pin_valid) begin
                if (pin == pin_q) begin
                    status_d = ST_OK; sv_d = 1'b1; state_d = S_WAIT_TXN;
                end else begin
                    tries_d = tries_q + 3'd1;
                    // The final wrong PIN reports nothing now; LOCKED follows the lock ack.
                    if (tries_q + 3'd1 == 3'(MAX_PIN_TRIES)) begin
                        req_d   = 1'b1;
                        op_d    = OP_LOCK;
                        state_d = S_LOCKING;
                    end else begin
                        status_d = ST_BAD_PIN; sv_d = 1'b1;
                    end
                end
            end
            S_LOCKING: if (ack) begin
                req_d = 1'b0; status_d = ST_LOCKED; sv_d = 1'b1; state_d = S_IDLE;
            end
            S_WAIT_TXN: if (txn_valid) begin
                txn_d   = transaction;
                amt_d   = amount;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WAIT_TXN;
                case (txn_q)
                    3'd1: if (amt_q > bal_q) begin
                        status_d = ST_INSUFF; sv_d = 1'b1;
                    end else begin
                        new_d = bal_q - amt_q; req_d = 1'b1; op_d = OP_WRITE; state_d = S_WRITE;
                    end
                    3'd2: if (sum[AMT_W]) begin
                        status_d = ST_OVERFLOW; sv_d = 1'b1;
                    end else begin
                        new_d = sum[AMT_W-1:0]; req_d = 1'b1; op_d = OP_WRITE; state_d = S_WRITE;
                    end
                    3'd3: begin status_d = ST_OK; sv_d = 1'b1; end
                    3'd4: begin status_d = ST_OK; sv_d = 1'b1; state_d = S_IDLE; end
                    default: begin status_d = ST_BAD_TXN; sv_d = 1'b1; end
                endcase
            end
            S_WRITE: if (ack) begin
                bal_d = new_q; req_d = 1'b0; status_d = ST_OK; sv_d = 1'b1; state_d = S_WAIT_TXN;
            end
            default: state_d = S_IDLE;
        endcase

        if (wait_st && !strobe_taken && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
            status_d = ST_TIMEOUT; sv_d = 1'b1; state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tries_q  <= '0;
            tmo_q    <= '0;
            card_q   <= '0;
            pin_q    <= '0;
            bal_q    <= '0;
            new_q    <= '0;
            txn_q    <= '0;
            amt_q    <= '0;
            req_q    <= 1'b0;
            op_q     <= '0;
            status_q <= '0;
            sv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            tmo_q    <= tmo_d;
            card_q   <= card_d;
            pin_q    <= pin_d;
            bal_q    <= bal_d;
            new_q    <= new_d;
            txn_q    <= txn_d;
            amt_q    <= amt_d;
            req_q    <= req_d;
            op_q     <= op_d;
            status_q <= status_d;
            sv_q     <= sv_d;
        end
    end

    assign acc_req      = req_q;
    assign acc_op       = op_q;
    assign acc_card     = card_q;
    assign acc_wdata    = new_q;
    assign balance_out  = bal_q;
    assign status       = status_q;
    assign status_valid = sv_q;
    assign busy         = (state_q != S_IDLE);
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: inputs driven after each falling edge,
// outputs checked on the following falling edge.
module tb_atm_session_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cardnumber = '0;
    logic        card_valid = 1'b0;
    logic [19:0] pin = '0;
    logic        pin_valid = 1'b0;
    logic [2:0]  transaction = '0;
    logic [15:0] amount = '0;
    logic        txn_valid = 1'b0;
    logic        acc_req;
    logic [1:0]  acc_op;
    logic [31:0] acc_card;
    logic [15:0] acc_wdata;
    logic        acc_ack = 1'b0;
    logic        acc_found = 1'b0;
    logic        acc_locked = 1'b0;
    logic [19:0] acc_pin = '0;
    logic [15:0] acc_balance = '0;
    logic [15:0] balance_out;
    logic [2:0]  status;
    logic        status_valid;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] CARD = 32'd11112222;

    atm_session_ctrl #(.MAX_PIN_TRIES(3), .TIMEOUT_CYCLES(10), .AMT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cardnumber(cardnumber), .card_valid(card_valid),
        .pin(pin), .pin_valid(pin_valid),
        .transaction(transaction), .amount(amount), .txn_valid(txn_valid),
        .acc_req(acc_req), .acc_op(acc_op), .acc_card(acc_card), .acc_wdata(acc_wdata),
        .acc_ack(acc_ack), .acc_found(acc_found), .acc_locked(acc_locked),
        .acc_pin(acc_pin), .acc_balance(acc_balance),
        .balance_out(balance_out), .status(status), .status_valid(status_valid),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic do_card(input logic [31:0] c);
        cardnumber = c; card_valid = 1'b1; @(negedge clk); card_valid = 1'b0;
    endtask

    task automatic do_pin(input logic [19:0] p);
        pin = p; pin_valid = 1'b1; @(negedge clk); pin_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [2:0] t, input logic [15:0] a);
        transaction = t; amount = a; txn_valid = 1'b1; @(negedge clk); txn_valid = 1'b0;
    endtask

    // Account store model: waits (bounded) for a request, optionally stalls, then acks.
    task automatic serve(input logic [1:0] exp_op, input int stall, input logic found,
                         input logic locked, input logic [19:0] spin, input logic [15:0] sbal);
        int n;
        logic bad;
        logic [31:0] c0;
        logic [15:0] w0;
        n = 0;
        while (acc_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", acc_req, 1);
        chk("acc_op", acc_op, exp_op);
        bad = 1'b0;
        c0 = acc_card;
        w0 = acc_wdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (acc_req !== 1'b1 || status_valid !== 1'b0 || acc_op !== exp_op ||
                acc_card !== c0 || acc_wdata !== w0) bad = 1'b1;
        end
        if (stall > 0) chk("stall_hold", bad, 0);
        acc_ack = 1'b1; acc_found = found; acc_locked = locked; acc_pin = spin; acc_balance = sbal;
        @(negedge clk);
        acc_ack = 1'b0; acc_found = 1'b0; acc_locked = 1'b0; acc_pin = '0; acc_balance = '0;
        chk("req_drop", acc_req, 0);
    endtask

    task automatic open_session(input logic [15:0] bal);
        do_start();
        do_card(CARD);
        serve(2'd0, 0, 1'b1, 1'b0, 20'd5432, bal);
        do_pin(20'd5432);
        chk("login_ok", {status_valid, status}, {1'b1, 3'd0});
    endtask

    initial begin
        logic bad;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_acc_req", acc_req, 0);
        chk("rst_acc_op", acc_op, 0);
        chk("rst_acc_card", acc_card, 0);
        chk("rst_acc_wdata", acc_wdata, 0);
        chk("rst_balance_out", balance_out, 0);
        chk("rst_status", status, 0);
        chk("rst_status_valid", status_valid, 0);
        chk("rst_busy", busy, 0);

        // Session 1: two wrong PINs then correct, then the transaction mix.
        do_start();
        chk("start_busy", busy, 1);
        do_card(CARD);
        chk("lookup_req", acc_req, 1);
        chk("lookup_op", acc_op, 0);
        chk("lookup_card", acc_card, CARD);
        serve(2'd0, 0, 1'b1, 1'b0, 20'd5432, 16'd1000);
        chk("lookup_no_status", status_valid, 0);
        do_pin(20'd1111);
        chk("pin1_valid", status_valid, 1);
        chk("pin1_status", status, 2);
        tick();
        chk("pin1_one_cycle", status_valid, 0);
        do_pin(20'd1112);
        chk("pin2_status", {status_valid, status}, {1'b1, 3'd2});
        do_pin(20'd5432);
        chk("pin3_status", {status_valid, status}, {1'b1, 3'd0});
        chk("pin3_no_lock", acc_req, 0);

        do_txn(3'd1, 16'd500);
        chk("wd500_exec_noreq", acc_req, 0);
        tick();
        chk("wd500_req", acc_req, 1);
        chk("wd500_op", acc_op, 1);
        chk("wd500_wdata", acc_wdata, 500);
        serve(2'd1, 0, 1'b0, 1'b0, 20'd0, 16'd0);
        chk("wd500_status", {status_valid, status}, {1'b1, 3'd0});
        chk("wd500_balance", balance_out, 500);

        do_txn(3'd1, 16'd600);
        tick();
        chk("wd600_status", {status_valid, status}, {1'b1, 3'd4});
        chk("wd600_noreq", acc_req, 0);

        do_txn(3'd2, 16'd300);
        tick();
        chk("dep300_wdata", acc_wdata, 800);
        serve(2'd1, 50, 1'b0, 1'b0, 20'd0, 16'd0);
        chk("dep300_status", {status_valid, status}, {1'b1, 3'd0});
        chk("dep300_balance", balance_out, 800);

        do_txn(3'd3, 16'd0);
        chk("bal_not_early", status_valid, 0);
        tick();
        chk("bal_status", {status_valid, status}, {1'b1, 3'd0});
        chk("bal_value", balance_out, 800);

        do_txn(3'd1, 16'd0);
        tick();
        chk("wd0_req", acc_req, 1);
        chk("wd0_wdata", acc_wdata, 800);
        serve(2'd1, 0, 1'b0, 1'b0, 20'd0, 16'd0);
        chk("wd0_status", {status_valid, status}, {1'b1, 3'd0});

        do_txn(3'd5, 16'd0);
        tick();
        chk("badtxn_status", {status_valid, status}, {1'b1, 3'd6});
        do_txn(3'd4, 16'd0);
        tick();
        chk("exit_status", {status_valid, status}, {1'b1, 3'd0});
        chk("exit_busy", busy, 0);

        // Session 2: three wrong PINs lock the card.
        do_start();
        do_card(CARD);
        serve(2'd0, 0, 1'b1, 1'b0, 20'd5432, 16'd1000);
        do_pin(20'd1);
        chk("lk_pin1", {status_valid, status}, {1'b1, 3'd2});
        do_pin(20'd2);
        chk("lk_pin2", {status_valid, status}, {1'b1, 3'd2});
        do_pin(20'd3);
        chk("lk_pin3_nostatus", status_valid, 0);
        chk("lk_req", acc_req, 1);
        chk("lk_op", acc_op, 2);
        serve(2'd2, 0, 1'b0, 1'b0, 20'd0, 16'd0);
        chk("lk_status", {status_valid, status}, {1'b1, 3'd3});
        chk("lk_busy", busy, 0);

        // Session 3: card already locked in the store.
        do_start();
        do_card(CARD);
        serve(2'd0, 0, 1'b1, 1'b1, 20'd5432, 16'd1000);
        chk("locked_status", {status_valid, status}, {1'b1, 3'd3});
        chk("locked_busy", busy, 0);

        // Session 4: unknown card.
        do_start();
        do_card(32'd99);
        serve(2'd0, 0, 1'b0, 1'b0, 20'd0, 16'd0);
        chk("nocard_status", {status_valid, status}, {1'b1, 3'd1});
        chk("nocard_busy", busy, 0);

        // Session 5: deposit overflow and the exact-fit boundary.
        open_session(16'd65000);
        do_txn(3'd2, 16'd1000);
        tick();
        chk("ovf_status", {status_valid, status}, {1'b1, 3'd5});
        chk("ovf_noreq", acc_req, 0);
        do_txn(3'd2, 16'd535);
        tick();
        chk("fit_req", acc_req, 1);
        chk("fit_wdata", acc_wdata, 65535);
        serve(2'd1, 0, 1'b0, 1'b0, 20'd0, 16'd0);
        chk("fit_balance", balance_out, 65535);
        do_txn(3'd4, 16'd0);
        tick();
        chk("s5_exit_busy", busy, 0);

        // Session 6: no PIN for TIMEOUT_CYCLES cycles.
        do_start();
        do_card(CARD);
        serve(2'd0, 0, 1'b1, 1'b0, 20'd5432, 16'd1000);
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (status_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("tmo_not_early", bad, 0);
        tick();
        chk("tmo_status", {status_valid, status}, {1'b1, 3'd7});
        chk("tmo_busy", busy, 0);

        // Session 7: reset while a WRITE request is outstanding, then a stray ack.
        open_session(16'd1000);
        do_txn(3'd1, 16'd100);
        tick();
        chk("rw_req", acc_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_req_cleared", acc_req, 0);
        chk("rw_busy", busy, 0);
        chk("rw_card", acc_card, 0);
        chk("rw_wdata", acc_wdata, 0);
        chk("rw_balance", balance_out, 0);
        chk("rw_sv", status_valid, 0);
        acc_ack = 1'b1; acc_found = 1'b1;
        tick();
        acc_ack = 1'b0; acc_found = 1'b0;
        tick();
        chk("late_ack_req", acc_req, 0);
        chk("late_ack_sv", status_valid, 0);
        chk("late_ack_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
